// File: rtl/pe1x1_psum_acc.sv
// ---------------------------------------------------------------------------
// pe1x1_psum_acc
//
// Partial-sum accumulator on the consumer side of the 1x1 PE array. It adds
// the PE product vector lane by lane over a runtime-programmed number of
// input channels, using signed saturating fixed-point adds. The finished
// vector goes to write-back over a valid/ready handshake. While a result is
// waiting in HOLD, in_rdy_o is low so the PE controller stalls.
//
// Ports:
//   clk        - clock; all logic runs on the rising edge
//   rst_n      - asynchronous active-low reset
//   clr_i      - synchronous abort; drops any group in progress or presented
//   cin_num_i  - channels per group (0 -> 1, >CIN_MAX -> CIN_MAX),
//                sampled on the first accept of a group
//   res_i      - PE product vector, lane k at [k*W +: W]
//   res_vld_i  - res_i is valid this cycle
//   in_rdy_o   - block can accept res_i this cycle (state ACC)
//   out_o      - accumulated vector, same lane packing as res_i
//   out_vld_o  - out_o holds a completed group (state HOLD)
//   out_rdy_i  - downstream takes out_o
//   ovf_o      - some lane saturated during the presented group
// ---------------------------------------------------------------------------
module pe1x1_psum_acc #(
  parameter int OUTPUT_NUM = 7,
  parameter int IW         = 24,
  parameter int FW         = 8,
  parameter int CIN_MAX    = 64,
  localparam int W         = IW + FW,
  localparam int CW        = $clog2(CIN_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic [CW-1:0]           cin_num_i,
  input  logic [OUTPUT_NUM*W-1:0] res_i,
  input  logic                    res_vld_i,
  output logic                    in_rdy_o,
  output logic [OUTPUT_NUM*W-1:0] out_o,
  output logic                    out_vld_o,
  input  logic                    out_rdy_i,
  output logic                    ovf_o
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [CW-1:0]                  cin_lat_q, cin_lat_d;
  logic [OUTPUT_NUM-1:0][W-1:0]   acc_q, acc_d;
  logic                           ovf_q, ovf_d;

  logic [OUTPUT_NUM-1:0][W-1:0]   res_lanes;
  logic [OUTPUT_NUM-1:0][W-1:0]   sum_val;
  logic [OUTPUT_NUM-1:0]          sum_ovf;
  logic [CW-1:0]                  cin_eff;
  logic                           accept;

  // Signed add in W+1 bits. The result has overflowed when its top two bits
  // differ, and the top bit then gives the direction. Returns
  // {saturated, value}.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      sat_add = s[W] ? {1'b1, MAX_NEG} : {1'b1, MAX_POS};
    end else begin
      sat_add = {1'b0, s[W-1:0]};
    end
  endfunction

  assign res_lanes = res_i;
  assign accept    = res_vld_i && (state_q == ACC);

  // A channel count of 0 means a single channel. Counts above CIN_MAX are
  // clamped so the counter can never run past its width.
  always_comb begin
    cin_eff = cin_num_i;
    if (cin_num_i == '0) begin
      cin_eff = CW'(1);
    end else if (cin_num_i > CW'(CIN_MAX)) begin
      cin_eff = CW'(CIN_MAX);
    end
  end

  // Saturating sum of every lane against the incoming product. These sums
  // are used only on accepts after the first one in a group.
  always_comb begin
    sum_val = '0;
    sum_ovf = '0;
    for (int k = 0; k < OUTPUT_NUM; k++) begin
      {sum_ovf[k], sum_val[k]} = sat_add(acc_q[k], res_lanes[k]);
    end
  end

  // Next-state logic. clr_i overrides everything else. The first accept of a
  // group loads the lanes and latches the channel count. Later accepts add
  // with saturation. The last accept moves to HOLD, where acc stays frozen
  // until downstream takes it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cin_lat_d = cin_lat_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (clr_i) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == '0) begin
              cin_lat_d = cin_eff;
              acc_d     = res_lanes;
              ovf_d     = 1'b0;
              if (cin_eff == CW'(1)) begin
                state_d = HOLD;
              end else begin
                cnt_d = CW'(1);
              end
            end else begin
              acc_d = sum_val;
              ovf_d = ovf_q | (|sum_ovf);
              if (cnt_q == cin_lat_q - CW'(1)) begin
                cnt_d   = '0;
                state_d = HOLD;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
        end
        HOLD: begin
          if (out_rdy_i) begin
            state_d = ACC;
          end
        end
        default: begin
          state_d = ACC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      cin_lat_q <= CW'(1);
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cin_lat_q <= cin_lat_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  // All outputs come straight from flops. ovf_o is gated so that it reads 0
  // whenever no result is being presented.
  assign in_rdy_o  = (state_q == ACC);
  assign out_vld_o = (state_q == HOLD);
  assign out_o     = acc_q;
  assign ovf_o     = ovf_q && (state_q == HOLD);

endmodule
